// File: rtl/ov5640_init_seq_if.sv
// IIC register-engine command port: start pulse and write word out, busy back.
interface ov5640_init_seq_if;
  logic        iic_start;
  logic [31:0] iic_wdata;
  logic        iic_busy;

  modport master (output iic_start, output iic_wdata, input iic_busy);
  modport slave  (input iic_start, input iic_wdata, output iic_busy);
endinterface

// File: rtl/ov5640_init_seq.sv
// OV5640 configuration sequencer: walks a synchronous ROM after power-up and
// issues one IIC write per entry, with ms delays, timeouts and bounded retry.
module ov5640_init_seq #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ACK_WAIT  = 16,
  parameter int unsigned BUSY_TO   = 1_000_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_done,
  input  logic                  re_init,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [31:0]           rom_data,
  ov5640_init_seq_if.master     iic,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_W-1:0]     err_addr
);

  localparam int unsigned MS_CYC   = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned WAIT_MAX = (ACK_WAIT > BUSY_TO) ? ACK_WAIT : BUSY_TO;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX) + 1;
  localparam int unsigned PRE_W    = $clog2(MS_CYC) + 1;
  localparam int unsigned MS_W     = 17;
  localparam int unsigned RTY_W    = $clog2(MAX_RETRY) + 1;

  localparam logic [WAIT_W-1:0] ACK_LAST  = WAIT_W'(ACK_WAIT - 1);
  localparam logic [WAIT_W-1:0] BUSY_LAST = WAIT_W'(BUSY_TO - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(MS_CYC - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_ACK,
    S_WAIT_BUSY, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                iic_start_q, iic_start_d;
  logic [31:0]         iic_wdata_q, iic_wdata_d;
  logic                init_done_q, init_done_d;
  logic                init_err_q, init_err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [31:0]         entry_q, entry_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic                timeout;

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    iic_start_d = 1'b0;
    iic_wdata_d = iic_wdata_q;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    err_addr_d  = err_addr_q;
    entry_d     = entry_q;
    wait_cnt_d  = wait_cnt_q;
    retry_d     = retry_q;
    pre_d       = pre_q;
    ms_d        = ms_q;
    timeout     = 1'b0;

    if (state_q != S_IDLE && !power_done) begin
      // Power loss aborts everything; the table reruns from 0 when it returns.
      state_d     = S_IDLE;
      rom_addr_d  = '0;
      iic_wdata_d = '0;
      init_done_d = 1'b0;
      init_err_d  = 1'b0;
      err_addr_d  = '0;
      entry_d     = '0;
      wait_cnt_d  = '0;
      retry_d     = '0;
      pre_d       = '0;
      ms_d        = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (power_done) begin
            state_d    = S_FETCH;
            rom_addr_d = '0;
          end
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          entry_d    = rom_data;
          wait_cnt_d = '0;
          pre_d      = '0;
          ms_d       = MS_W'(rom_data[15:0]);
          if (rom_data[31:24] == 8'hFF) begin
            state_d     = S_DONE;
            init_done_d = 1'b1;
          end else if (rom_data[31:24] == 8'hFE) begin
            state_d = S_DELAY;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!iic.iic_busy) begin
            iic_start_d = 1'b1;
            iic_wdata_d = entry_q;
            wait_cnt_d  = '0;
            state_d     = S_WAIT_ACK;
          end else if (wait_cnt_q == BUSY_LAST) begin
            timeout = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        S_WAIT_ACK: begin
          if (iic.iic_busy) begin
            wait_cnt_d = '0;
            state_d    = S_WAIT_BUSY;
          end else if (wait_cnt_q == ACK_LAST) begin
            timeout = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        S_WAIT_BUSY: begin
          if (!iic.iic_busy) begin
            state_d = S_NEXT;
          end else if (wait_cnt_q == BUSY_LAST) begin
            timeout = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        S_DELAY: begin
          if (ms_q == '0) begin
            state_d = S_NEXT;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            ms_d  = ms_q - MS_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        S_NEXT: begin
          retry_d = '0;
          if (rom_addr_q == '1) begin
            state_d     = S_DONE;
            init_done_d = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end
        S_DONE, S_ERROR: begin
          if (re_init) begin
            state_d     = S_FETCH;
            rom_addr_d  = '0;
            init_done_d = 1'b0;
            init_err_d  = 1'b0;
            retry_d     = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Shared timeout handling for ISSUE, WAIT_ACK and WAIT_BUSY.
      if (timeout) begin
        if (retry_q < RTY_MAX) begin
          retry_d    = retry_q + RTY_W'(1);
          wait_cnt_d = '0;
          state_d    = S_ISSUE;
        end else begin
          state_d    = S_ERROR;
          init_err_d = 1'b1;
          err_addr_d = rom_addr_q;
        end
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      iic_start_q <= 1'b0;
      iic_wdata_q <= '0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      err_addr_q  <= '0;
      entry_q     <= '0;
      wait_cnt_q  <= '0;
      retry_q     <= '0;
      pre_q       <= '0;
      ms_q        <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      iic_start_q <= iic_start_d;
      iic_wdata_q <= iic_wdata_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      err_addr_q  <= err_addr_d;
      entry_q     <= entry_d;
      wait_cnt_q  <= wait_cnt_d;
      retry_q     <= retry_d;
      pre_q       <= pre_d;
      ms_q        <= ms_d;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign iic.iic_start = iic_start_q;
  assign iic.iic_wdata = iic_wdata_q;
  assign init_done     = init_done_q;
  assign init_err      = init_err_q;
  assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Bench for ov5640_init_seq: ROM + IIC engine models, table-driven runs and
// directed sequences for delay, retry, stuck-busy, abort and no-wrap cases.
module tb_ov5640_init_seq;

  localparam int unsigned TB_CLK_HZ = 2_000_000;
  localparam int          MS        = TB_CLK_HZ / 1000;
  localparam int          ACK_WAIT  = 16;
  localparam int          BUSY_TO   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1: ADDR_W = 8 ----------------
  logic        pd = 1'b0, re = 1'b0;
  logic [7:0]  rom_addr, eaddr;
  logic [31:0] rom_data;
  logic        done, err;
  logic [31:0] rom_mem [256];
  ov5640_init_seq_if ifc();

  ov5640_init_seq #(.CLK_HZ(TB_CLK_HZ), .ADDR_W(8), .ACK_WAIT(ACK_WAIT),
                    .BUSY_TO(BUSY_TO), .MAX_RETRY(3)) u_dut (
    .clk(clk), .rst(rst), .power_done(pd), .re_init(re),
    .rom_addr(rom_addr), .rom_data(rom_data), .iic(ifc),
    .init_done(done), .init_err(err), .err_addr(eaddr));

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int          eng_len = 10;
  int          eng_cnt;
  logic        fail_en = 1'b0;
  logic [31:0] fail_word = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ifc.iic_busy <= 1'b0;
      eng_cnt      <= 0;
    end else if (ifc.iic_start && !(fail_en && ifc.iic_wdata == fail_word)) begin
      ifc.iic_busy <= 1'b1;
      eng_cnt      <= eng_len - 1;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
    end else begin
      ifc.iic_busy <= 1'b0;
    end
  end

  int          p_cyc[$];
  logic [31:0] p_dat[$];
  int          f_cyc[$];
  logic        prev_start = 1'b0, prev_busy = 1'b0;
  int          viol = 0;
  always @(negedge clk) begin
    if (ifc.iic_start) begin
      p_cyc.push_back(cyc);
      p_dat.push_back(ifc.iic_wdata);
      if (ifc.iic_busy || prev_start) viol <= viol + 1;
    end
    if (prev_busy && !ifc.iic_busy) f_cyc.push_back(cyc);
    prev_start <= ifc.iic_start;
    prev_busy  <= ifc.iic_busy;
  end

  // ---------------- DUT 2: ADDR_W = 2 ----------------
  logic        pd2 = 1'b0, re2 = 1'b0;
  logic [1:0]  rom_addr2, eaddr2;
  logic [31:0] rom_data2;
  logic        done2, err2;
  logic [31:0] rom2_mem [4];
  ov5640_init_seq_if ifc2();

  ov5640_init_seq #(.CLK_HZ(TB_CLK_HZ), .ADDR_W(2), .ACK_WAIT(ACK_WAIT),
                    .BUSY_TO(BUSY_TO), .MAX_RETRY(3)) u_dut2 (
    .clk(clk), .rst(rst), .power_done(pd2), .re_init(re2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .iic(ifc2),
    .init_done(done2), .init_err(err2), .err_addr(eaddr2));

  always @(posedge clk) rom_data2 <= rom2_mem[rom_addr2];

  int eng2_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ifc2.iic_busy <= 1'b0;
      eng2_cnt      <= 0;
    end else if (ifc2.iic_start) begin
      ifc2.iic_busy <= 1'b1;
      eng2_cnt      <= 9;
    end else if (eng2_cnt != 0) begin
      eng2_cnt <= eng2_cnt - 1;
    end else begin
      ifc2.iic_busy <= 1'b0;
    end
  end

  logic [31:0] p2_dat[$];
  always @(negedge clk) if (ifc2.iic_start) p2_dat.push_back(ifc2.iic_wdata);

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dat_at(input int i);
    return (i < p_dat.size()) ? p_dat[i] : 32'hBAD0BAD0;
  endfunction
  function automatic int cyc_at(input int i);
    return (i < p_cyc.size()) ? p_cyc[i] : -1000000;
  endfunction
  function automatic int fall_at(input int i);
    return (i < f_cyc.size()) ? f_cyc[i] : -1000000;
  endfunction

  int pd_cyc;

  task automatic start_run();
    pd = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 200 && ifc.iic_busy; i++) @(negedge clk);
    @(negedge clk);
    p_cyc.delete(); p_dat.delete(); f_cyc.delete();
    pd     = 1'b1;
    pd_cyc = cyc;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
  endtask

  task automatic load_rom(input logic [31:0] w0, w1, w2, w3);
    for (int i = 0; i < 256; i++) rom_mem[i] = 32'hFF000000;
    rom_mem[0] = w0; rom_mem[1] = w1; rom_mem[2] = w2; rom_mem[3] = w3;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0][31:0] rom;
    logic             fail_en;
    logic [31:0]      fail_word;
    int               exp_n;
    logic [31:0]      exp_first;
    logic [31:0]      exp_last;
    logic             exp_done;
    logic             exp_err;
    logic [7:0]       exp_eaddr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3,
                              input logic fe, input logic [31:0] fw, input int n,
                              input logic [31:0] first, last,
                              input logic d, e, input logic [7:0] ea);
    vec_t v;
    v.rom[0] = w0; v.rom[1] = w1; v.rom[2] = w2; v.rom[3] = w3;
    v.fail_en = fe; v.fail_word = fw; v.exp_n = n;
    v.exp_first = first; v.exp_last = last;
    v.exp_done = d; v.exp_err = e; v.exp_eaddr = ea;
    return v;
  endfunction

  vec_t vecs[5];
  int   gap, err_cyc;

  initial begin
    vecs[0] = mk(32'h78300811, 32'h78300882, 32'hFF000000, 32'hFF000000,
                 1'b0, 32'h0, 2, 32'h78300811, 32'h78300882, 1'b1, 1'b0, 8'd0);
    vecs[1] = mk(32'h78301111, 32'hFE000000, 32'h78302222, 32'hFF000000,
                 1'b0, 32'h0, 2, 32'h78301111, 32'h78302222, 1'b1, 1'b0, 8'd0);
    vecs[2] = mk(32'hFF000000, 32'h78300811, 32'h78300882, 32'hFF000000,
                 1'b0, 32'h0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 8'd0);
    vecs[3] = mk(32'h78300811, 32'h78300882, 32'hDEADBEEF, 32'hFF000000,
                 1'b1, 32'hDEADBEEF, 6, 32'h78300811, 32'hDEADBEEF, 1'b0, 1'b1, 8'd2);
    vecs[4] = mk(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hFF000000,
                 1'b0, 32'h0, 3, 32'h11223344, 32'h99AABBCC, 1'b1, 1'b0, 8'd0);

    rom2_mem[0] = 32'h78300001; rom2_mem[1] = 32'h78300002;
    rom2_mem[2] = 32'h78300003; rom2_mem[3] = 32'h78300004;
    load_rom(32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hFF000000);

    // Reset values, and IDLE holds while power_done is low.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_start", 32'(ifc.iic_start), 32'h0);
    chk("rst_wdata", ifc.iic_wdata, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_addr", 32'(eaddr), 32'h0);

    // Table-driven runs.
    for (int k = 0; k < 5; k++) begin
      pd = 1'b0;
      @(negedge clk);
      load_rom(vecs[k].rom[0], vecs[k].rom[1], vecs[k].rom[2], vecs[k].rom[3]);
      fail_en   = vecs[k].fail_en;
      fail_word = vecs[k].fail_word;
      eng_len   = 10;
      start_run();
      wait_end(2000);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_pulses", k), 32'(p_dat.size()), 32'(vecs[k].exp_n));
      if (vecs[k].exp_n > 0) begin
        chk($sformatf("v%0d_first", k), dat_at(0), vecs[k].exp_first);
        chk($sformatf("v%0d_last", k), dat_at(vecs[k].exp_n - 1), vecs[k].exp_last);
      end
      chk($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].exp_done));
      chk($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
      if (vecs[k].exp_err) chk($sformatf("v%0d_err_addr", k), 32'(eaddr), 32'(vecs[k].exp_eaddr));
    end
    fail_en = 1'b0;

    // 5 ms delay between two writes. Fixed sequencing around the delay:
    // NEXT,FETCH,LATCH before it, one extra DELAY cycle, then
    // NEXT,FETCH,LATCH,ISSUE and the registered pulse after it = 9 cycles.
    pd = 1'b0;
    @(negedge clk);
    load_rom(32'h78300811, 32'hFE000005, 32'h78300882, 32'hFF000000);
    start_run();
    wait_end(5 * MS + 500);
    chk("delay_pulses", 32'(p_dat.size()), 32'd2);
    chk("delay_second", dat_at(1), 32'h78300882);
    chk("delay_done", 32'(done), 32'h1);
    gap = cyc_at(1) - fall_at(0);
    n_chk++;
    if (gap < 5 * MS + 9 - 5 || gap > 5 * MS + 9 + 5) begin
      n_err++;
      $display("FAIL delay_gap: got %0d expected %0d +/-5", gap, 5 * MS + 9);
    end

    // Engine never acks the second entry: 4 issues spaced ACK_WAIT+1, then error.
    pd = 1'b0;
    @(negedge clk);
    load_rom(32'h78300811, 32'hDEADBEEF, 32'hFF000000, 32'hFF000000);
    fail_en   = 1'b1;
    fail_word = 32'hDEADBEEF;
    start_run();
    wait_end(2000);
    err_cyc = cyc;
    chk("nack_pulses", 32'(p_dat.size()), 32'd5);
    for (int i = 1; i < 4; i++)
      chk($sformatf("nack_space%0d", i), 32'(cyc_at(i + 1) - cyc_at(i)), 32'(ACK_WAIT + 1));
    chk("nack_data", dat_at(4), 32'hDEADBEEF);
    chk("nack_err", 32'(err), 32'h1);
    chk("nack_done", 32'(done), 32'h0);
    chk("nack_err_addr", 32'(eaddr), 32'h1);
    chk("nack_err_rise", 32'(err_cyc - cyc_at(4)), 32'(ACK_WAIT));
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk("reinit_err_clear", 32'(err), 32'h0);
    chk("reinit_err_addr_kept", 32'(eaddr), 32'h1);
    chk("reinit_addr0", 32'(rom_addr), 32'h0);
    fail_en = 1'b0;

    // Busy stuck past BUSY_TO: retry, and ISSUE holds until busy falls.
    pd = 1'b0;
    @(negedge clk);
    load_rom(32'h78300811, 32'hFF000000, 32'hFF000000, 32'hFF000000);
    eng_len = BUSY_TO + 15;
    start_run();
    for (int i = 0; i < 100 && !ifc.iic_busy; i++) @(negedge clk);
    eng_len = 10;
    wait_end(2000);
    chk("first_start_latency", 32'(cyc_at(0) - pd_cyc), 32'd4);
    chk("stuck_pulses", 32'(p_dat.size()), 32'd2);
    chk("stuck_retry_space", 32'(cyc_at(1) - cyc_at(0)), 32'(BUSY_TO + 15 + 2));
    chk("stuck_after_fall", 32'(cyc_at(1) - fall_at(0)), 32'd1);
    chk("stuck_done", 32'(done), 32'h1);

    // power_done dropped in WAIT_BUSY of the second write.
    pd = 1'b0;
    @(negedge clk);
    load_rom(32'h78300811, 32'h78300882, 32'hFF000000, 32'hFF000000);
    start_run();
    for (int i = 0; i < 200 && !(p_dat.size() == 2 && ifc.iic_busy); i++) @(negedge clk);
    @(negedge clk);
    pd = 1'b0;
    @(negedge clk);
    chk("abort_rom_addr", 32'(rom_addr), 32'h0);
    chk("abort_start", 32'(ifc.iic_start), 32'h0);
    chk("abort_wdata", ifc.iic_wdata, 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_err", 32'(err), 32'h0);
    repeat (20) @(negedge clk);
    chk("abort_no_start", 32'(p_dat.size()), 32'd2);
    start_run();
    wait_end(2000);
    chk("restart_first", dat_at(0), 32'h78300811);
    chk("restart_pulses", 32'(p_dat.size()), 32'd2);
    chk("restart_done", 32'(done), 32'h1);

    // ADDR_W=2, no end marker: stops at the last address, re_init reruns.
    pd2 = 1'b1;
    for (int i = 0; i < 200 && p2_dat.size() < 1; i++) @(negedge clk);
    re2 = 1'b1;
    @(negedge clk);
    re2 = 1'b0;
    for (int i = 0; i < 500 && !done2; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("nowrap_pulses", 32'(p2_dat.size()), 32'd4);
    chk("nowrap_last", (p2_dat.size() > 3) ? p2_dat[3] : 32'hBAD0BAD0, 32'h78300004);
    chk("nowrap_done", 32'(done2), 32'h1);
    chk("nowrap_err", 32'(err2), 32'h0);
    chk("nowrap_addr", 32'(rom_addr2), 32'h3);
    re2 = 1'b1;
    @(negedge clk);
    re2 = 1'b0;
    chk("rerun_done_clear", 32'(done2), 32'h0);
    chk("rerun_addr0", 32'(rom_addr2), 32'h0);
    for (int i = 0; i < 500 && !done2; i++) @(negedge clk);
    chk("rerun_pulses", 32'(p2_dat.size()), 32'd8);
    chk("rerun_first", (p2_dat.size() > 4) ? p2_dat[4] : 32'hBAD0BAD0, 32'h78300001);
    chk("rerun_done", 32'(done2), 32'h1);

    chk("start_while_busy_or_back_to_back", 32'(viol), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ov5640_init_seq.md
# ov5640_init_seq

Table-driven configuration sequencer for the OV5640 SCCB/IIC register engine. After sensor power-up completes, it walks a synchronous configuration ROM and issues one write per entry through the engine's estart/ewdata port. It honours delay and end-of-table entries, enforces per-transaction timeouts with bounded retry, and reports done/error to the camera top level. It sits between power_ctrl and ov5640_cfg, replacing the manual estart/ewdata drive.

## Interface
- CLK_HZ, 50_000_000: clock frequency; ms tick = CLK_HZ/1000 cycles
- ADDR_W, 8: ROM address width
- ACK_WAIT, 16: cycles allowed for iic_busy to rise after iic_start
- BUSY_TO, 1_000_000: cycles allowed for iic_busy to fall (20 ms)
- MAX_RETRY, 3: re-issues per entry before error

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst  in  1  asynchronous, active-high reset
- power_done  in  1  sensor power sequence complete (level)
- re_init  in  1  one-cycle pulse; restarts the table from address 0, honoured only in DONE/ERROR
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  32  ROM word, valid one cycle after rom_addr
- iic_start  out  1  one-cycle start pulse to the IIC engine
- iic_wdata  out  32  entry forwarded to the engine; stable from iic_start until next issue
- iic_busy  in  1  engine busy
- init_done  out  1  table completed (level)
- init_err  out  1  entry failed after retries (level)
- err_addr  out  ADDR_W  address of the failing entry

## Operation
- Entry decode on rom_data[31:24]:
  - 8'hFF: end of table
  - 8'hFE: delay of rom_data[15:0] ms
  - otherwise: IIC write, whole word forwarded to iic_wdata
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_ACK, WAIT_BUSY, DELAY, NEXT, DONE, ERROR.
- IDLE -> FETCH when power_done=1 (first time after reset), with rom_addr=0.
- FETCH (address presented) -> LATCH (rom_data sampled into entry register and decoded):
  - end -> DONE
  - delay -> DELAY
  - write -> ISSUE
- ISSUE: waits while iic_busy=1, counting toward BUSY_TO. When iic_busy=0, pulses iic_start for one cycle -> WAIT_ACK.
- WAIT_ACK:
  - iic_busy=1 within ACK_WAIT cycles -> WAIT_BUSY
  - else timeout
- WAIT_BUSY: iic_busy=0 -> NEXT; BUSY_TO cycles elapsed -> timeout.
- Timeout: if retry count < MAX_RETRY, increment it and go to ISSUE with the same entry; else go to ERROR with err_addr=current address.
- DELAY: counts N full ms ticks, then -> NEXT. N=0 goes to NEXT on the next cycle.
- NEXT: clears the retry count.
  - if rom_addr = 2^ADDR_W-1 -> DONE (no wrap)
  - else increments rom_addr -> FETCH
- DONE: init_done=1. ERROR: init_err=1. Both are held until re_init (-> FETCH, addr 0, flags cleared, err_addr kept until the next error) or rst.
- power_done falling in any state other than IDLE: abort at once.
  - -> IDLE; flags, counters and rom_addr cleared; no iic_start issued.
  - The table reruns when power_done returns.
- re_init in any state other than DONE/ERROR: ignored.
- Counter widths: ceil(log2(max)) + 1. The ms prescaler and the ms counter are separate; there is no multiplication.

## Timing
- Reset values: rom_addr=0, iic_start=0, iic_wdata=0, init_done=0, init_err=0, err_addr=0, state=IDLE.
- ROM latency is exactly 1 cycle; no other combinational path from rom_data to outputs.
- Write entry with idle engine: FETCH -> LATCH -> ISSUE. iic_start is high in the 3rd cycle after FETCH entry, registered.
- Entry-to-entry overhead, excluding engine time: 4 cycles (FETCH, LATCH, ISSUE, NEXT).
- iic_start is never high for two consecutive cycles, and never asserted while iic_busy=1.
- init_done/init_err rise the cycle after LATCH (end marker) or after the final timeout.
- The delay of N ms lasts N*CLK_HZ/1000 cycles, ±1 cycle.

## Test plan
- ROM {0x78300811, 0x78300882, 0xFF000000}, engine model busy 10 cycles after start:
  - exactly 2 iic_start pulses, carrying ewdata 0x78300811 then 0x78300882
  - init_done=1, init_err=0
- Delay entry 0xFE000005 between two writes:
  - gap between the busy fall and the next iic_start is 5*50_000 cycles, ±5
- Engine never raises busy, MAX_RETRY=3:
  - 4 start pulses on the same entry, each spaced ACK_WAIT+1 cycles
  - init_err=1, err_addr=the entry's address
- Busy stuck high after ack:
  - BUSY_TO timeout followed by retry; ISSUE waits for busy low before pulsing
- power_done dropped in WAIT_BUSY:
  - -> IDLE next cycle, outputs at reset values
  - on power_done restore, restarts at addr 0
- Table with no 0xFF and ADDR_W=2, 4 writes:
  - 4 pulses, then init_done with no wrap
  - re_init pulse in DONE reruns all 4; re_init while running is ignored
